// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the SS.hh BCD stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t HUN_MAX      = 4'd9;
    localparam bcd_t SEC_ONES_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with synchronous clear, increment and a combinational carry-out
// that fires when an increment arrives at MAX.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = HUN_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    input  logic wrapEn,
    output bcd_t digit,
    output logic carry
);

    bcd_t r_digit;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_digit <= '0;
        end else if (inc) begin
            if (r_digit == MAX) begin
                if (wrapEn) begin
                    r_digit <= '0;
                end
            end else begin
                r_digit <= r_digit + 4'd1;
            end
        end
    end

    assign digit = r_digit;
    assign carry = inc && (r_digit == MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// SS.hh stopwatch advanced one hundredth per rising edge of tickIn, with a
// start/pause/clear FSM and optional wrap at 59.99.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tickIn,
    input  logic       startStop,
    input  logic       clear,
    output logic [3:0] secTens,
    output logic [3:0] secOnes,
    output logic [3:0] hunTens,
    output logic [3:0] hunOnes,
    output logic       running,
    output logic       done,
    output logic       rollover
);

    sw_state_t r_state;
    logic      r_tickPrev;
    logic      r_ssPrev;
    logic      r_running;
    logic      r_done;
    logic      r_rollover;

    logic w_tickEdge;
    logic w_ssEdge;
    logic w_atMax;
    logic w_inc;
    logic w_c0, w_c1, w_c2, w_c3;
    bcd_t w_hunOnes, w_hunTens, w_secOnes, w_secTens;

    assign w_tickEdge = tickIn & ~r_tickPrev;
    assign w_ssEdge   = startStop & ~r_ssPrev;
    assign w_atMax    = (w_secTens == SEC_TENS_MAX) && (w_secOnes == SEC_ONES_MAX) &&
                        (w_hunTens == HUN_MAX) && (w_hunOnes == HUN_MAX);

    // In saturating mode the tick at 59.99 must not reach the lower digits,
    // otherwise they would roll to zero while secTens holds.
    assign w_inc = (r_state == RUNNING) && w_tickEdge && !((WRAP == 1'b0) && w_atMax);

    bcd_digit #(.MAX(HUN_MAX)) u_hunOnes (
        .clk(clk), .reset(reset), .clr(clear), .inc(w_inc), .wrapEn(1'b1),
        .digit(w_hunOnes), .carry(w_c0)
    );

    bcd_digit #(.MAX(HUN_MAX)) u_hunTens (
        .clk(clk), .reset(reset), .clr(clear), .inc(w_c0), .wrapEn(1'b1),
        .digit(w_hunTens), .carry(w_c1)
    );

    bcd_digit #(.MAX(SEC_ONES_MAX)) u_secOnes (
        .clk(clk), .reset(reset), .clr(clear), .inc(w_c1), .wrapEn(1'b1),
        .digit(w_secOnes), .carry(w_c2)
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_secTens (
        .clk(clk), .reset(reset), .clr(clear), .inc(w_c2), .wrapEn(WRAP),
        .digit(w_secTens), .carry(w_c3)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_rollover <= 1'b0;
            r_tickPrev <= 1'b1;
            r_ssPrev   <= 1'b1;
        end else begin
            r_tickPrev <= tickIn;
            r_ssPrev   <= startStop;
            if (clear) begin
                r_state    <= IDLE;
                r_running  <= 1'b0;
                r_done     <= 1'b0;
                r_rollover <= 1'b0;
            end else begin
                r_rollover <= w_c3;
                case (r_state)
                    IDLE: begin
                        if (w_ssEdge) begin
                            r_state   <= RUNNING;
                            r_running <= 1'b1;
                        end
                    end
                    RUNNING: begin
                        if (w_tickEdge && w_atMax && (WRAP == 1'b0)) begin
                            r_state   <= DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end else if (w_ssEdge) begin
                            r_state   <= PAUSED;
                            r_running <= 1'b0;
                        end
                    end
                    PAUSED: begin
                        if (w_ssEdge) begin
                            r_state   <= RUNNING;
                            r_running <= 1'b1;
                        end
                    end
                    DONE: begin
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                        r_done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign secTens  = w_secTens;
    assign secOnes  = w_secOnes;
    assign hunTens  = w_hunTens;
    assign hunOnes  = w_hunOnes;
    assign running  = r_running;
    assign done     = r_done;
    assign rollover = r_rollover;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench: one wrapping and one saturating stopwatch driven in lockstep.
module tb_stopwatch_counter;

    logic clk = 1'b0;
    logic reset, tickIn, startStop, clear;

    logic [3:0] stW, soW, htW, hoW, stS, soS, htS, hoS;
    logic       runW, doneW, rollW, runS, doneS, rollS;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    always #5 clk = ~clk;

    stopwatch_counter #(.WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .tickIn(tickIn), .startStop(startStop), .clear(clear),
        .secTens(stW), .secOnes(soW), .hunTens(htW), .hunOnes(hoW),
        .running(runW), .done(doneW), .rollover(rollW)
    );

    stopwatch_counter #(.WRAP(1'b0)) dut_s (
        .clk(clk), .reset(reset), .tickIn(tickIn), .startStop(startStop), .clear(clear),
        .secTens(stS), .secOnes(soS), .hunTens(htS), .hunOnes(hoS),
        .running(runS), .done(doneS), .rollover(rollS)
    );

    wire [15:0] dispW = {stW, soW, htW, hoW};
    wire [15:0] dispS = {stS, soS, htS, hoS};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tickIn = 1'b1; step();
        tickIn = 1'b0; step();
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic press();
        startStop = 1'b1; step();
        startStop = 1'b0; step();
    endtask

    initial begin
        reset = 1'b1; tickIn = 1'b1; startStop = 1'b1; clear = 1'b0;
        step(); step();
        chk("reset_disp", dispW, 16'h0000);
        chk("reset_flags", 16'({runW, doneW, rollW, runS, doneS, rollS}), 16'h0000);

        // Release with both inputs already high: no edge must be seen.
        reset = 1'b0;
        for (int unsigned i = 0; i < 10; i++) step();
        chk("held_high_disp", dispW, 16'h0000);
        chk("held_high_run", 16'({runW, runS}), 16'h0000);
        tickIn = 1'b0; startStop = 1'b0; step();

        startStop = 1'b1; step();
        chk("start_latency", 16'({runW, runS}), 16'h0003);
        startStop = 1'b0; step();
        ticks(123);
        chk("count_0123_w", dispW, 16'h0123);
        chk("count_0123_s", dispS, 16'h0123);
        press();
        chk("paused_run", 16'({runW, runS}), 16'h0000);
        ticks(5);
        chk("paused_hold", dispW, 16'h0123);
        press();
        tick();
        chk("resume_0124", dispW, 16'h0124);
        chk("resume_run", 16'(runW), 16'h0001);

        ticks(5875);
        chk("at_5999_w", dispW, 16'h5999);
        chk("at_5999_s", dispS, 16'h5999);
        tickIn = 1'b1; step();
        chk("wrap_disp", dispW, 16'h0000);
        chk("wrap_roll", 16'(rollW), 16'h0001);
        chk("wrap_run", 16'(runW), 16'h0001);
        chk("sat_disp", dispS, 16'h5999);
        chk("sat_flags", 16'({doneS, runS, rollS}), 16'h0004);
        tickIn = 1'b0; step();
        chk("roll_one_cycle", 16'(rollW), 16'h0000);
        ticks(2);
        chk("wrap_0002", dispW, 16'h0002);
        chk("sat_hold", dispS, 16'h5999);
        press();
        chk("done_ignores_ss", 16'({doneS, runS}), 16'h0002);
        chk("done_w_never", 16'(doneW), 16'h0000);
        clear = 1'b1; step();
        chk("clear_disp_s", dispS, 16'h0000);
        chk("clear_flags", 16'({doneS, runS, runW}), 16'h0000);

        // Button pressed while clear is held must not start after clear drops.
        startStop = 1'b1; step();
        clear = 1'b0; step();
        chk("held_through_clear", 16'({runW, runS}), 16'h0000);
        startStop = 1'b0; step();

        press();
        ticks(9);
        chk("at_0009", dispW, 16'h0009);
        tickIn = 1'b1; startStop = 1'b1; step();
        chk("tick_ss_disp", dispW, 16'h0010);
        chk("tick_ss_paused", 16'({runW, runS}), 16'h0000);
        tickIn = 1'b0; startStop = 1'b0; step();
        press();
        clear = 1'b1; tickIn = 1'b1; step();
        chk("clear_tick_disp", dispW, 16'h0000);
        chk("clear_tick_run", 16'({runW, runS}), 16'h0000);
        clear = 1'b0; tickIn = 1'b0; step();
        tick();
        chk("idle_no_count", dispW, 16'h0000);

        // Start and tick together in IDLE: tick is not counted.
        startStop = 1'b1; tickIn = 1'b1; step();
        chk("idle_ss_tick_run", 16'(runW), 16'h0001);
        chk("idle_ss_tick_disp", dispW, 16'h0000);
        startStop = 1'b0; tickIn = 1'b0; step();
        ticks(3745);
        chk("at_3745", dispW, 16'h3745);
        reset = 1'b1; tickIn = 1'b1; step();
        chk("mid_reset_disp", dispW, 16'h0000);
        chk("mid_reset_flags", 16'({runW, rollW, runS, rollS}), 16'h0000);
        reset = 1'b0; tickIn = 1'b0; step();
        chk("post_reset_disp", dispS, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Seconds/hundredths stopwatch that consumes the divided clock from the clock divider (configured for 100 Hz) and keeps a four-digit BCD time SS.hh. It runs entirely in the `clk` domain: it detects rising edges of the divided clock and advances the count one hundredth per edge under a start/pause/clear state machine. Its BCD outputs feed the seven-segment display driver downstream.

## Interface
- `WRAP`, default 1: 1 = roll over from 59.99 to 00.00 and keep running; 0 = saturate at 59.99 and stop.
- `clk` input 1: system clock, the same clock that drives the divider.
- `reset` input 1: synchronous, active-high reset.
- `tickIn` input 1: divided clock (`outClk` of the divider), a registered square wave in the `clk` domain.
- `startStop` input 1: start/pause request, level; acts on its rising edge.
- `clear` input 1: level; zeroes the count and returns to IDLE.
- `secTens` output 4: BCD 0–5.
- `secOnes` output 4: BCD 0–9.
- `hunTens` output 4: BCD 0–9.
- `hunOnes` output 4: BCD 0–9.
- `running` output 1: high in RUNNING.
- `done` output 1: high in DONE (WRAP=0 only).
- `rollover` output 1: one-cycle pulse on wrap 59.99→00.00 (WRAP=1 only).

## Operation
- Edge detect:
  - `tickEdge = tickIn & ~tickPrev`.
  - `ssEdge = startStop & ~ssPrev`.
  - Both previous-value registers reset to 1, so an input already high at reset release does not count as an edge.
- States:
  - IDLE (count 00.00) -> RUNNING on `ssEdge`.
  - RUNNING -> PAUSED on `ssEdge`.
  - PAUSED -> RUNNING on `ssEdge`.
  - RUNNING -> DONE on a tick at 59.99 when WRAP=0.
  - DONE ignores `ssEdge`.
  - Any state -> IDLE on `clear`.
- Counting:
  - Only in RUNNING, only on `tickEdge`.
  - Increment is a BCD ripple: `hunOnes` 9->0 carries into `hunTens`, 9->0 into `secOnes`, 9->0 into `secTens`. `secTens` wraps 5->0 (WRAP=1) or holds (WRAP=0).
  - No digit ever leaves its legal range.
- Priority within one cycle, highest first: `reset` > `clear` > (`tickEdge` count, evaluated on current state) > `ssEdge` transition.
  - A tick and a pause request in the same RUNNING cycle: the tick is counted, then the block enters PAUSED.
  - An `ssEdge` in IDLE together with a tick: the block enters RUNNING, and that tick is not counted.
- `clear` held high keeps the block in IDLE. An `ssEdge` is still recorded in `ssPrev`, so a button held through the release of `clear` does not start the stopwatch.
- Reset or `clear` in the middle of any operation zeroes all digits. Neither produces a `rollover` pulse.

## Timing
- Reset values:
  - All digits 0.
  - `running` = 0, `done` = 0, `rollover` = 0.
  - State IDLE.
  - `tickPrev` = 1, `ssPrev` = 1.
- All outputs are registered.
- Count latency: `tickIn` rises at cycle N -> digits updated at cycle N+1. The same applies to `rollover`, which is high for cycle N+1 only.
- `startStop` rises at cycle N -> `running` changes at cycle N+1.
- `clear` high at cycle N -> digits are 0 and the state is IDLE at cycle N+1.
- Tick spacing is at least 2 `clk` cycles by construction. The block must nevertheless tolerate ticks 2 cycles apart without loss.

## Structure
- Shared package `stopwatch_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} sw_state_t`.
  - `typedef logic [3:0] bcd_t`.
  - Constants `HUN_MAX = 9`, `SEC_ONES_MAX = 9`, `SEC_TENS_MAX = 5`.
- Sub-module `bcd_digit`:
  - Parameter `MAX`.
  - Ports: `clk`, `reset`, `clr`, `inc`, `wrapEn`, output `digit`, output `carry` (combinational, equal to `inc && digit == MAX`).
  - Four instances, chained by `carry`.
- The top level holds the edge detectors, the FSM and the `rollover`/`done` logic.

## Test plan
- Reset release with `tickIn` and `startStop` both held 1: no count and state IDLE; all digits stay 0 for 10 cycles.
- Start, then 123 tick edges: the display reads 01.23 and `running` = 1. Pause, then 5 ticks: the display stays 01.23. Resume, then 1 tick: 01.24.
- WRAP=1: preload by ticking to 59.99, then 1 tick: the display reads 00.00, `rollover` is high for exactly 1 cycle, and `running` stays 1.
- WRAP=0: tick to 59.99, then 3 more ticks: the display holds 59.99, `done` = 1, `running` = 0, and `ssEdge` is ignored. After `clear`, the display reads 00.00 and the state is IDLE.
- Same-cycle events while RUNNING at 00.09:
  - `tickEdge` + `ssEdge` -> 00.10 and PAUSED.
  - `clear` + `tickEdge` -> 00.00 and IDLE.
- `reset` asserted at 37.45 while RUNNING, in the same cycle as a tick -> all digits 0, IDLE, and no `rollover`.
